// File: rtl/vproc_mmu.sv
// vproc_mmu: decodes vector-processor memory requests onto 10-bit GPIO registers or a read-only SPI flash.
// Optional macro VPROC_MMU_DEBUG_EN mirrors the last accepted address[11:2] onto the GPIO pins.
module vproc_mmu #(
   parameter int unsigned MEM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_programming_mode,
   input  logic             set_debug_mode,
   input  logic             vproc_mem_req_o,
   input  logic [31:0]      vproc_mem_addr_o,
   input  logic             vproc_mem_we_o,
   input  logic [3:0]       vproc_mem_be_o,
   input  logic [MEM_W-1:0] vproc_mem_wdata_o,
   output logic             vproc_mem_rvalid_i,
   output logic             vproc_mem_err_i,
   output logic [MEM_W-1:0] vproc_mem_rdata_i,
   inout  logic [9:0]       gpio_pins,
   input  logic [3:0]       external_qspi_io_i,
   output logic [3:0]       external_qspi_io_o,
   output logic [3:0]       external_qspi_io_t,
   output logic             external_qspi_ck_o,
   output logic             external_qspi_cs_o,
   input  logic [3:0]       programming_qspi_io_i,
   output logic [3:0]       programming_qspi_io_o,
   output logic [3:0]       programming_qspi_io_t,
   output logic             programming_qspi_ck_o,
   output logic             programming_qspi_cs_o
);

   localparam logic [31:0] ADDR_GPIO_OUT = 32'h0000_0000;
   localparam logic [31:0] ADDR_GPIO_OE  = 32'h0000_0004;
   localparam logic [31:0] ADDR_GPIO_IN  = 32'h0000_0008;
   localparam logic [31:0] ADDR_FLASH_LO = 32'h0000_2000;
   localparam logic [31:0] ADDR_FLASH_HI = 32'h0100_1FFF;

   typedef enum logic [2:0] {
      IDLE, GPIO_RSP, ERR_RSP, SPI_CMD, SPI_ADDR, SPI_DATA, SPI_END
   } state_t;

   state_t           state_q, state_d;
   logic [9:0]       gpio_out_q, gpio_out_d;
   logic [9:0]       gpio_oe_q, gpio_oe_d;
   logic             cs_q, cs_d;
   logic             ck_q, ck_d;
   logic             prog_q, prog_d;
   logic [5:0]       bit_q, bit_d;
   logic [31:0]      tx_q, tx_d;
   logic [31:0]      rx_q, rx_d;
   logic             rvalid_q, rvalid_d;
   logic             err_q, err_d;
   logic [MEM_W-1:0] rdata_q, rdata_d;

   logic        accept;
   logic        is_flash;
   logic [23:0] flash_off;
   logic        rx_bit;
   logic        cs_low;
   logic        mosi;
   logic [9:0]  pin_oe;
   logic [9:0]  pin_val;

   // The rvalid cycle of a flash read already sits in IDLE; the held request must not be re-accepted there.
   assign accept    = (state_q == IDLE) && vproc_mem_req_o && !rvalid_q;
   assign is_flash  = (vproc_mem_addr_o >= ADDR_FLASH_LO) && (vproc_mem_addr_o <= ADDR_FLASH_HI);
   assign flash_off = vproc_mem_addr_o[23:0] - ADDR_FLASH_LO[23:0];
   assign rx_bit    = prog_q ? programming_qspi_io_i[1] : external_qspi_io_i[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         cs_q       <= 1'b1;
         ck_q       <= 1'b0;
         prog_q     <= 1'b0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         gpio_out_q <= gpio_out_d;
         gpio_oe_q  <= gpio_oe_d;
         cs_q       <= cs_d;
         ck_q       <= ck_d;
         prog_q     <= prog_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gpio_out_d = gpio_out_q;
      gpio_oe_d  = gpio_oe_q;
      cs_d       = cs_q;
      ck_d       = ck_q;
      prog_d     = prog_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rvalid_d   = 1'b0;
      err_d      = 1'b0;
      rdata_d    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = GPIO_RSP;
               rvalid_d = 1'b1;
               if (vproc_mem_we_o && vproc_mem_addr_o == ADDR_GPIO_OUT) begin
                  if (vproc_mem_be_o[0]) gpio_out_d[7:0] = vproc_mem_wdata_o[7:0];
                  if (vproc_mem_be_o[1]) gpio_out_d[9:8] = vproc_mem_wdata_o[9:8];
               end else if (vproc_mem_we_o && vproc_mem_addr_o == ADDR_GPIO_OE) begin
                  if (vproc_mem_be_o[0]) gpio_oe_d[7:0] = vproc_mem_wdata_o[7:0];
                  if (vproc_mem_be_o[1]) gpio_oe_d[9:8] = vproc_mem_wdata_o[9:8];
               end else if (!vproc_mem_we_o && vproc_mem_addr_o == ADDR_GPIO_OUT) begin
                  rdata_d = {22'b0, gpio_out_q};
               end else if (!vproc_mem_we_o && vproc_mem_addr_o == ADDR_GPIO_OE) begin
                  rdata_d = {22'b0, gpio_oe_q};
               end else if (!vproc_mem_we_o && vproc_mem_addr_o == ADDR_GPIO_IN) begin
                  rdata_d = {22'b0, gpio_pins};
               end else if (!vproc_mem_we_o && is_flash) begin
                  state_d  = SPI_CMD;
                  rvalid_d = 1'b0;
                  cs_d     = 1'b0;
                  ck_d     = 1'b0;
                  bit_d    = '0;
                  tx_d     = {8'h03, flash_off};
                  rx_d     = '0;
                  prog_d   = set_programming_mode;
               end else begin
                  state_d = ERR_RSP;
                  err_d   = 1'b1;
               end
            end
         end
         GPIO_RSP, ERR_RSP: state_d = IDLE;
         SPI_CMD, SPI_ADDR, SPI_DATA: begin
            // bit_q counts SCK periods: 0-7 command, 8-31 address, 32-63 data.
            if (!ck_q) begin
               ck_d = 1'b1;
               if (state_q == SPI_DATA) rx_d = {rx_q[30:0], rx_bit};
            end else begin
               ck_d  = 1'b0;
               bit_d = bit_q + 6'd1;
               tx_d  = {tx_q[30:0], 1'b0};
               if (bit_q == 6'd63) begin
                  state_d = SPI_END;
                  cs_d    = 1'b1;
               end else if (bit_q == 6'd7) begin
                  state_d = SPI_ADDR;
               end else if (bit_q == 6'd31) begin
                  state_d = SPI_DATA;
               end
            end
         end
         SPI_END: begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            rdata_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
         end
         default: state_d = IDLE;
      endcase
   end

   assign vproc_mem_rvalid_i = rvalid_q;
   assign vproc_mem_err_i    = err_q;
   assign vproc_mem_rdata_i  = rdata_q;

   // Chip select releases combinationally in the reset cycle itself, not one cycle later.
   assign cs_low = !cs_q && !rst;
   assign mosi   = cs_low && (state_q == SPI_CMD || state_q == SPI_ADDR) && tx_q[31];

   assign external_qspi_cs_o    = !(cs_low && !prog_q);
   assign external_qspi_ck_o    = ck_q && cs_low && !prog_q;
   assign external_qspi_io_o    = {3'b000, mosi && !prog_q};
   assign external_qspi_io_t    = (cs_low && !prog_q) ? 4'b1110 : 4'b1111;
   assign programming_qspi_cs_o = !(cs_low && prog_q);
   assign programming_qspi_ck_o = ck_q && cs_low && prog_q;
   assign programming_qspi_io_o = {3'b000, mosi && prog_q};
   assign programming_qspi_io_t = (cs_low && prog_q) ? 4'b1110 : 4'b1111;

`ifdef VPROC_MMU_DEBUG_EN
   logic [9:0] dbg_q;

   always_ff @(posedge clk) begin
      if (rst) dbg_q <= '0;
      else if (accept) dbg_q <= vproc_mem_addr_o[11:2];
   end

   assign pin_oe  = set_debug_mode ? '1 : gpio_oe_q;
   assign pin_val = set_debug_mode ? dbg_q : gpio_out_q;

   logic unused_ok;
   assign unused_ok = ^{vproc_mem_wdata_o[MEM_W-1:10], vproc_mem_be_o[3:2],
                        external_qspi_io_i[3:2], external_qspi_io_i[0],
                        programming_qspi_io_i[3:2], programming_qspi_io_i[0]};
`else
   assign pin_oe  = gpio_oe_q;
   assign pin_val = gpio_out_q;

   logic unused_ok;
   assign unused_ok = ^{set_debug_mode, vproc_mem_wdata_o[MEM_W-1:10], vproc_mem_be_o[3:2],
                        external_qspi_io_i[3:2], external_qspi_io_i[0],
                        programming_qspi_io_i[3:2], programming_qspi_io_i[0]};
`endif

   for (genvar i = 0; i < 10; i++) begin : g_pin
      assign gpio_pins[i] = pin_oe[i] ? pin_val[i] : 1'bz;
   end

endmodule

// File: tb/tb_vproc_mmu.sv
// Bench for vproc_mmu: directed test-plan steps plus randomized requests against an address-map model and SPI flash model.
module tb_vproc_mmu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        set_programming_mode = 1'b0;
   logic        set_debug_mode = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid, err;
   logic [31:0] rdata;
   tri1  [9:0]  gpio_pins;
   logic [3:0]  ext_io_i, ext_io_o, ext_io_t, prg_io_i, prg_io_o, prg_io_t;
   logic        ext_ck, ext_cs, prg_ck, prg_cs;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   vproc_mmu #(.MEM_W(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .set_programming_mode (set_programming_mode),
      .set_debug_mode       (set_debug_mode),
      .vproc_mem_req_o      (req),
      .vproc_mem_addr_o     (addr),
      .vproc_mem_we_o       (we),
      .vproc_mem_be_o       (be),
      .vproc_mem_wdata_o    (wdata),
      .vproc_mem_rvalid_i   (rvalid),
      .vproc_mem_err_i      (err),
      .vproc_mem_rdata_i    (rdata),
      .gpio_pins            (gpio_pins),
      .external_qspi_io_i   (ext_io_i),
      .external_qspi_io_o   (ext_io_o),
      .external_qspi_io_t   (ext_io_t),
      .external_qspi_ck_o   (ext_ck),
      .external_qspi_cs_o   (ext_cs),
      .programming_qspi_io_i(prg_io_i),
      .programming_qspi_io_o(prg_io_o),
      .programming_qspi_io_t(prg_io_t),
      .programming_qspi_ck_o(prg_ck),
      .programming_qspi_cs_o(prg_cs)
   );

   // Flash contents: fixed bytes 11 22 33 44 at 0x4, a scrambled pattern elsewhere.
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      case (a)
         24'h4:   return 8'h11;
         24'h5:   return 8'h22;
         24'h6:   return 8'h33;
         24'h7:   return 8'h44;
         default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
      endcase
   endfunction

   // SPI mode-0 flash devices, index 0 = storage port, 1 = programming port.
   logic [3:0]  m_io [2] = '{4'h0, 4'h0};
   int          m_n [2] = '{0, 0};
   logic [31:0] m_hdr [2] = '{32'h0, 32'h0};
   int          cs_falls [2] = '{0, 0};
   logic [1:0]  m_cs_prev = 2'b11;
   logic [1:0]  m_ck_prev = 2'b00;

   assign ext_io_i = m_io[0];
   assign prg_io_i = m_io[1];

   always @(negedge clk) begin
      logic sck, csn, si;
      int idx;
      logic [7:0] by;
      for (int p = 0; p < 2; p++) begin
         sck = (p == 0) ? ext_ck : prg_ck;
         csn = (p == 0) ? ext_cs : prg_cs;
         si  = (p == 0) ? ext_io_o[0] : prg_io_o[0];
         if (!csn && m_cs_prev[p]) begin
            m_n[p] = 0;
            cs_falls[p]++;
         end
         if (csn) begin
            m_io[p] = 4'h0;
         end else if (sck && !m_ck_prev[p]) begin
            if (m_n[p] < 32) m_hdr[p] = {m_hdr[p][30:0], si};
            m_n[p]++;
         end else if (!sck && m_ck_prev[p] && m_n[p] >= 32 && m_n[p] < 64) begin
            idx = m_n[p] - 32;
            by = flash_byte(m_hdr[p][23:0] + 24'(idx / 8));
            m_io[p] = {2'b00, by[3'(7 - idx % 8)], 1'b0};
         end
         m_cs_prev[p] = csn;
         m_ck_prev[p] = sck;
      end
   end

   // Register-level model of the GPIO block.
   logic [9:0]  m_out = '0;
   logic [9:0]  m_oe = '0;
   logic [31:0] m_last = '0;

   function automatic logic [9:0] model_pins();
      logic [9:0] pv;
      for (int i = 0; i < 10; i++) pv[i] = m_oe[i] ? m_out[i] : 1'b1;
`ifdef VPROC_MMU_DEBUG_EN
      if (set_debug_mode) pv = m_last[11:2];
`endif
      return pv;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic       o_cs1, o_cs128, o_cs129;
   logic [3:0] o_iot1, o_ioto1, o_ioo129;

   // One request with the requester holding req until rvalid; lat = cycles from accept edge, -1 on timeout.
   task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                       input logic pm, output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      addr = a; we = w; be = b; wdata = d; set_programming_mode = pm; req = 1'b1;
      @(posedge clk);
      lat = -1; rd = '0; er = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) begin
            o_cs1   = pm ? prg_cs : ext_cs;
            o_iot1  = pm ? prg_io_t : ext_io_t;
            o_ioto1 = pm ? ext_io_t : prg_io_t;
         end
         if (c == 128) o_cs128 = pm ? prg_cs : ext_cs;
         if (c == 129) begin
            o_cs129  = pm ? prg_cs : ext_cs;
            o_ioo129 = pm ? prg_io_o : ext_io_o;
         end
         if (rvalid) begin
            lat = c; rd = rdata; er = err;
            break;
         end
      end
      req = 1'b0; we = 1'b0;
   endtask

   // Predicts the response from the address map, runs the request, checks it, then updates the model.
   task automatic run(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                      input logic pm, input logic dbg);
      logic [31:0] erd, rd, t;
      logic        eer, er, fl;
      int          elat, lat, f0, f1, sel;
      logic [23:0] off;
      set_debug_mode = dbg;
      fl = !w && a >= 32'h0000_2000 && a <= 32'h0100_1FFF;
      erd = '0; eer = 1'b0; elat = 1; off = '0;
      if (fl) begin
         t = a - 32'h2000;
         off = t[23:0];
         erd = {flash_byte(off + 24'd3), flash_byte(off + 24'd2), flash_byte(off + 24'd1), flash_byte(off)};
         elat = 130;
      end else if (!w && a == 32'h0) erd = {22'b0, m_out};
      else if (!w && a == 32'h4) erd = {22'b0, m_oe};
      else if (!w && a == 32'h8) erd = {22'b0, model_pins()};
      else if (!(w && (a == 32'h0 || a == 32'h4))) eer = 1'b1;
      f0 = cs_falls[0]; f1 = cs_falls[1];
      xact(a, w, b, d, pm, rd, er, lat);
      check("latency", lat, elat);
      check("err", {31'b0, er}, {31'b0, eer});
      check("rdata", rd, erd);
      if (fl) begin
         sel = pm ? 1 : 0;
         check("cmd_addr", m_hdr[sel], {8'h03, off});
         check("cs_sel_falls", cs_falls[sel] - (pm ? f1 : f0), 1);
         check("cs_oth_falls", cs_falls[1 - sel] - (pm ? f0 : f1), 0);
         check("cs_c1", {31'b0, o_cs1}, 0);
         check("cs_c128", {31'b0, o_cs128}, 0);
         check("cs_c129", {31'b0, o_cs129}, 1);
         check("io_t_sel", {28'b0, o_iot1}, 32'hE);
         check("io_t_oth", {28'b0, o_ioto1}, 32'hF);
         check("io_o_c129", {28'b0, o_ioo129}, 0);
      end else begin
         check("cs_quiet", (cs_falls[0] - f0) + (cs_falls[1] - f1), 0);
      end
      for (int i = 0; i < 10; i++) begin
         if (w && a == 32'h0 && b[i / 8]) m_out[i] = d[i];
         if (w && a == 32'h4 && b[i / 8]) m_oe[i] = d[i];
      end
      m_last = a;
      @(negedge clk);
      check("pins", {22'b0, gpio_pins}, {22'b0, model_pins()});
   endtask

   initial begin
      logic [31:0] ra, rd;
      logic        er, seen;
      int          lat, kind, f0;
      logic [31:0] err_addrs [6];
      err_addrs = '{32'h0000_1000, 32'h0000_1FFC, 32'h0100_2000, 32'h0000_000C, 32'h0000_0010, 32'hFFFF_FFFC};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ext_cs", {31'b0, ext_cs}, 1);
      check("rst_prg_cs", {31'b0, prg_cs}, 1);
      check("rst_ext_io_t", {28'b0, ext_io_t}, 32'hF);
      check("rst_prg_io_t", {28'b0, prg_io_t}, 32'hF);
      check("rst_ck", {30'b0, ext_ck, prg_ck}, 0);
      check("rst_io_o", {24'b0, ext_io_o, prg_io_o}, 0);
      check("rst_pins_z", {22'b0, gpio_pins}, 32'h3FF);
      check("rst_rvalid", {31'b0, rvalid}, 0);

      // Test-plan sequence.
      run(32'h4, 1'b1, 4'hF, 32'h3FF, 1'b0, 1'b0);
      run(32'h0, 1'b1, 4'hF, 32'h155, 1'b0, 1'b0);
      check("pins_155", {22'b0, gpio_pins}, 32'h155);
      run(32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      run(32'h8, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      run(32'h2004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      xact(32'h2004, 1'b0, 4'h0, 32'h0, 1'b0, rd, er, lat);
      check("flash_4433_2211", rd, 32'h4433_2211);
      run(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      run(32'h3000, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run(32'h8, 1'b1, 4'hF, 32'h3FF, 1'b0, 1'b0);
      run(32'h2000, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
      run(32'h0100_1FFC, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

      // Reset in cycle 60 of a flash read.
      @(negedge clk);
      addr = 32'h2010; we = 1'b0; set_programming_mode = 1'b0; req = 1'b1;
      f0 = cs_falls[0];
      @(posedge clk);
      repeat (59) @(posedge clk);
      @(negedge clk);
      check("mid_cs_low", {31'b0, ext_cs}, 0);
      @(posedge clk);
      #1 rst = 1'b1; req = 1'b0;
      @(negedge clk);
      check("rstmid_ext_cs", {31'b0, ext_cs}, 1);
      check("rstmid_prg_cs", {31'b0, prg_cs}, 1);
      check("rstmid_io_t", {28'b0, ext_io_t}, 32'hF);
      check("rstmid_rvalid", {31'b0, rvalid}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (150) begin
         @(negedge clk);
         if (rvalid) seen = 1'b1;
      end
      check("rstmid_no_rvalid", {31'b0, seen}, 0);
      check("rstmid_one_cs", cs_falls[0] - f0, 1);
      m_out = '0; m_oe = '0; m_last = '0;
      check("rstmid_pins_z", {22'b0, gpio_pins}, 32'h3FF);
      run(32'h2004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

      // Randomized traffic over the whole address map.
      for (int k = 0; k < 36; k++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1: run($urandom_range(0, 1) ? 32'h4 : 32'h0, 1'b1, 4'($urandom_range(0, 15)), $urandom,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            2, 8: begin
               ra = 32'($urandom_range(0, 2)) * 4;
               run(ra, 1'b0, 4'h0, 32'h0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            end
            3, 4: begin
               ra = 32'h2000 + ({8'h0, 24'($urandom)} & 32'h00FF_FFFC);
               run(ra, 1'b0, 4'h0, 32'h0, 1'($urandom_range(0, 1)), 1'b0);
            end
            5: run(err_addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 4'hF, $urandom,
                   1'($urandom_range(0, 1)), 1'b0);
            6: run(32'h2000 + ({8'h0, 24'($urandom)} & 32'h00FF_FFFC), 1'b1, 4'hF, $urandom, 1'b0, 1'b0);
            7: run(32'h8, 1'b1, 4'hF, $urandom, 1'b0, 1'b0);
            default: run($urandom_range(0, 1) ? 32'h2000 : 32'h0100_1FFC, 1'b0, 4'h0, 32'h0,
                         1'($urandom_range(0, 1)), 1'b0);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vproc_mmu.md
# vproc_mmu

Memory-mapping unit between the vector processor's data/instruction memory port and the chip's peripherals. It decodes each request address and serves it from a memory-mapped 10-bit GPIO block or from an external read-only SPI flash, using the storage QSPI port or, in programming mode, the programming QSPI port. It returns one response per request using the processor's `rvalid`/`err`/`rdata` protocol. Unmapped or illegal accesses complete with an error response.

## Interface
- `MEM_W`, 32: data width of the processor memory port; only 32 is supported.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `set_programming_mode`  in  1  selects the programming QSPI port for flash reads; sampled when a request is accepted.
- `set_debug_mode`  in  1  enables the debug mirror on the GPIO pins; see Configuration.
- `vproc_mem_req_o`  in  1  request valid.
- `vproc_mem_addr_o`  in  32  byte address, word aligned.
- `vproc_mem_we_o`  in  1  write enable.
- `vproc_mem_be_o`  in  4  byte enables.
- `vproc_mem_wdata_o`  in  32  write data.
- `vproc_mem_rvalid_i`  out  1  one-cycle response strobe.
- `vproc_mem_err_i`  out  1  error flag; valid only while `rvalid` is high.
- `vproc_mem_rdata_i`  out  32  read data; valid only while `rvalid` is high.
- `gpio_pins`  inout  10  bidirectional GPIO pins.
- `external_qspi_io_i` / `_io_o` / `_io_t`  in/out/out  4 each  storage flash data in, data out, and tristate control (1 = high-Z).
- `external_qspi_ck_o`, `external_qspi_cs_o`  out  1 each  storage flash SCK and active-low chip select.
- `programming_qspi_*`  same set of signals as the storage port, for the programming flash.

## Operation
- Address map:
  - 0x0000_0000 GPIO_OUT: read/write, bits [9:0].
  - 0x0000_0004 GPIO_OE: read/write, bits [9:0]; 1 = pin driven.
  - 0x0000_0008 GPIO_IN: read-only pin levels.
  - 0x0000_2000–0x0100_1FFF: flash, read-only; flash byte address = addr − 0x2000 (24 bits).
  - Any other address, any write to flash, or any write to GPIO_IN: error response with `rdata` = 0.
- GPIO register writes honour `be`.
- `gpio_pins[i]` = GPIO_OE[i] ? GPIO_OUT[i] : Z.
- GPIO reads return the value zero-extended to 32 bits.
- FSM states: IDLE, GPIO_RSP, ERR_RSP, SPI_CMD, SPI_ADDR, SPI_DATA, SPI_END.
- `req` is sampled only in IDLE. While busy, `req` is ignored; the requester holds its request signals until `rvalid`.
- Flash read uses single-bit SPI mode 0:
  - Command 0x03, then a 24-bit address, both MSB first on `io_o[0]`.
  - Then 32 data bits sampled from `io_i[1]`.
  - Bytes assemble little-endian: the first received byte goes to `rdata[7:0]`, each byte MSB first.
- Tristate control:
  - While the selected port's `cs` is low: `io_t` = 4'b1110.
  - Otherwise, and always on the unselected port: `io_t` = 4'b1111.
  - `io_o` = 0 whenever it is not shifting.
- Reset values:
  - `rvalid` = 0, `err` = 0, `rdata` = 0.
  - Both ports: `cs` = 1, `ck` = 0, `io_o` = 0, `io_t` = 4'hF.
  - GPIO_OUT = 0, GPIO_OE = 0 (all pins high-Z).
  - FSM in IDLE.
- Reset mid-transaction: on the reset cycle `cs` returns high, no `rvalid` is produced, and the FSM goes to IDLE.

## Timing
- Call the accept edge (`req` high in IDLE) cycle 0.
- GPIO and error responses: `rvalid` is high in cycle 1. A GPIO write takes effect at the same edge.
- Flash read:
  - `cs_o` goes low in cycle 1 and stays low for 128 cycles, which is 64 SCK periods of 2 clk each.
  - Each SCK period: `ck` low for one cycle, then high for one cycle. `io_o` changes while `ck` is low; `io_i` is sampled on the rising edge of `ck`.
  - `cs_o` goes high in cycle 129.
  - `rvalid` is high for one cycle in cycle 130; the FSM returns to IDLE in the same cycle.
- A new request may be accepted in the cycle after `rvalid`.
- `set_programming_mode` changes take effect only for requests accepted after the change.

## Configuration
- `VPROC_MMU_DEBUG_EN` defined:
  - While `set_debug_mode` = 1, `gpio_pins` are forced to output `vproc_mem_addr_o[11:2]` of the last accepted request, ignoring GPIO_OE and GPIO_OUT.
  - The GPIO registers remain readable and writable.
- `VPROC_MMU_DEBUG_EN` undefined: `set_debug_mode` is ignored and no debug logic is built.

## Test plan
- After reset: `cs_o` = 1, `io_t` = 4'hF, `gpio_pins` = Z, `rvalid` = 0.
- Write 0x3FF to GPIO_OE, then 0x155 to GPIO_OUT → `gpio_pins` = 10'h155. Reading GPIO_OUT returns 0x0000_0155 in cycle 1 with `err` = 0.
- Read 0x0000_2004 with a flash model holding bytes 11 22 33 44 at 0x4:
  - bus shows 0x03 then 0x000004 on `io_o[0]`;
  - `rdata` = 0x4433_2211 with `rvalid` in cycle 130, `err` = 0.
- Read 0x0000_1000, and write 0x0000_3000 → each returns `rvalid` in cycle 1 with `err` = 1 and `rdata` = 0. No `cs` activity.
- `set_programming_mode` = 1, then read 0x2000 → only `programming_qspi_cs_o` toggles; `external_qspi_cs_o` stays 1.
- Assert `rst` in cycle 60 of a flash read → `cs_o` = 1 in that cycle and no `rvalid`. A following read completes normally.
